// File: rtl/sdram_pkg.sv
// Shared SDRAM constants: command codes, idle bus values, address layout, state encoding.
package sdram_pkg;

    localparam int unsigned CMD_W     = 4;
    localparam int unsigned BA_W      = 2;
    localparam int unsigned ADDR_W    = 11;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned ADDR_IN_W = 21;
    localparam int unsigned LEN_W     = 10;

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [CMD_W-1:0] CMD_NOP        = 4'b0111;
    localparam logic [CMD_W-1:0] CMD_ACTIVE     = 4'b0011;
    localparam logic [CMD_W-1:0] CMD_WRITE      = 4'b0100;
    localparam logic [CMD_W-1:0] CMD_BURST_STOP = 4'b0110;
    localparam logic [CMD_W-1:0] CMD_PRECHARGE  = 4'b0010;

    localparam logic [BA_W-1:0]   BA_DEFAULT     = 2'b11;
    localparam logic [ADDR_W-1:0] ADDR_DEFAULT   = 11'h7ff;
    localparam logic [ADDR_W-1:0] ADDR_ALL_BANKS = 11'h400;

    // Flat request address is {bank, row, col}
    localparam int unsigned BANK_MSB = 20;
    localparam int unsigned BANK_LSB = 19;
    localparam int unsigned ROW_MSB  = 18;
    localparam int unsigned ROW_LSB  = 8;
    localparam int unsigned COL_LSB  = 0;

    typedef enum logic [3:0] {
        WR_IDLE,
        WR_ACTIVE,
        WR_TRCD,
        WR_WRITE,
        WR_DATA,
        WR_STOP,
        WR_TWR,
        WR_PRE,
        WR_TRP,
        WR_END
    } wr_state_t;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Bits needed to hold values 0..max_val
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sdram_wait_cnt.sv
// Per-state cycle counter: cleared on state change, flags when the terminal count is reached.
module sdram_wait_cnt #(
    parameter int unsigned CNT_W = 9
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             clr,
    input  logic [CNT_W-1:0] tc,
    output logic             done_c
);

    logic [CNT_W-1:0] cnt;

    // Count up from zero, hold at the terminal count until the next clear
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (!done_c) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign done_c = (cnt == tc);

endmodule

// File: rtl/sdram_write.sv
// SDRAM write-burst engine: ACTIVE, full-page WRITE, BURST_STOP, PRECHARGE, streaming FIFO words to DQ.
module sdram_write
    import sdram_pkg::*;
#(
    parameter int unsigned TRCD_CLK = 2,
    parameter int unsigned TWR_CLK  = 2,
    parameter int unsigned TRP_CLK  = 2,
    parameter int unsigned COL_W    = 8
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic                 init_end,
    input  logic                 wr_en,
    input  logic [ADDR_IN_W-1:0] wr_addr_in,
    input  logic [LEN_W-1:0]     wr_burst_len,
    input  logic [DATA_W-1:0]    wr_data,
    output logic                 wr_ack,
    output logic                 wr_end,
    output logic [CMD_W-1:0]     wr_cmd,
    output logic [BA_W-1:0]      wr_ba,
    output logic [ADDR_W-1:0]    wr_addr,
    output logic                 wr_sdram_en,
    output logic [DATA_W-1:0]    wr_sdram_data
);

    localparam int unsigned PAGE_WORDS = 1 << COL_W;
    localparam int unsigned CNT_W =
        cnt_width(max_u(max_u(PAGE_WORDS, TRCD_CLK), max_u(TWR_CLK, TRP_CLK)));

    // Terminal counts are (cycles in state - 1); only used when the state lasts at least one cycle
    localparam logic [CNT_W-1:0] TC_TRCD = CNT_W'(TRCD_CLK - 2);
    localparam logic [CNT_W-1:0] TC_TWR  = CNT_W'(TWR_CLK - 2);
    localparam logic [CNT_W-1:0] TC_TRP  = CNT_W'(TRP_CLK - 2);

    wr_state_t              state;
    wr_state_t              state_next;
    logic [ADDR_IN_W-1:0]   addr_q;
    logic [LEN_W-1:0]       len_q;
    logic [CNT_W-1:0]       tc;
    logic                   done;
    logic                   start;

    assign start = (state == WR_IDLE) && (state_next == WR_ACTIVE);

    // State register
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= WR_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Capture address and length for the whole burst; a zero length is treated as one word
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            addr_q <= '0;
            len_q  <= '0;
        end else if (start) begin
            addr_q <= wr_addr_in;
            len_q  <= (wr_burst_len == '0) ? LEN_W'(1) : wr_burst_len;
        end
    end

    sdram_wait_cnt #(
        .CNT_W (CNT_W)
    ) u_wait_cnt (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .clr       (state_next != state),
        .tc        (tc),
        .done_c    (done)
    );

    // Next state and command/address decode
    always_comb begin
        state_next = state;
        tc         = '0;
        wr_cmd     = CMD_NOP;
        wr_ba      = BA_DEFAULT;
        wr_addr    = ADDR_DEFAULT;
        wr_end     = 1'b0;
        case (state)
            WR_IDLE: begin
                if (init_end && wr_en) begin
                    state_next = WR_ACTIVE;
                end
            end
            WR_ACTIVE: begin
                wr_cmd     = CMD_ACTIVE;
                wr_ba      = addr_q[BANK_MSB:BANK_LSB];
                wr_addr    = addr_q[ROW_MSB:ROW_LSB];
                state_next = (TRCD_CLK > 1) ? WR_TRCD : WR_WRITE;
            end
            WR_TRCD: begin
                tc = TC_TRCD;
                if (done) begin
                    state_next = WR_WRITE;
                end
            end
            WR_WRITE: begin
                wr_cmd     = CMD_WRITE;
                wr_ba      = addr_q[BANK_MSB:BANK_LSB];
                wr_addr    = ADDR_W'(addr_q[COL_LSB+COL_W-1:COL_LSB]);
                state_next = (len_q > LEN_W'(1)) ? WR_DATA : WR_STOP;
            end
            WR_DATA: begin
                tc = CNT_W'(len_q - LEN_W'(2));
                if (done) begin
                    state_next = WR_STOP;
                end
            end
            WR_STOP: begin
                wr_cmd     = CMD_BURST_STOP;
                state_next = (TWR_CLK > 1) ? WR_TWR : WR_PRE;
            end
            WR_TWR: begin
                tc = TC_TWR;
                if (done) begin
                    state_next = WR_PRE;
                end
            end
            WR_PRE: begin
                wr_cmd     = CMD_PRECHARGE;
                wr_addr    = ADDR_ALL_BANKS;
                state_next = (TRP_CLK > 1) ? WR_TRP : WR_END;
            end
            WR_TRP: begin
                tc = TC_TRP;
                if (done) begin
                    state_next = WR_END;
                end
            end
            WR_END: begin
                wr_end     = 1'b1;
                state_next = WR_IDLE;
            end
            default: begin
                state_next = WR_IDLE;
            end
        endcase
    end

    // Data path: one FIFO word per cycle during WRITE and DATA
    assign wr_sdram_en   = (state == WR_WRITE) || (state == WR_DATA);
    assign wr_ack        = wr_sdram_en;
    assign wr_sdram_data = wr_sdram_en ? wr_data : '0;

endmodule

// File: tb/tb_sdram_write.sv
// Directed bench for sdram_write: default timing instance and a (3,1,3) timing instance.
module tb_sdram_write;
    import sdram_pkg::*;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic        init_end;
    logic        wr_en_a, wr_en_b;
    logic [20:0] wr_addr_in;
    logic [9:0]  wr_burst_len;
    logic [31:0] wr_data;

    logic        ack_a, end_a, en_a, ack_b, end_b, en_b;
    logic [3:0]  cmd_a, cmd_b;
    logic [1:0]  ba_a, ba_b;
    logic [10:0] addr_a, addr_b;
    logic [31:0] data_a, data_b;

    logic        sel;
    logic        m_ack, m_end, m_en;
    logic [3:0]  m_cmd;
    logic [1:0]  m_ba;
    logic [10:0] m_addr;
    logic [31:0] m_data;

    int          n_checks, n_bad, cyc, idx;
    logic        last_ack;
    logic [7:0]  burst_tag;
    int          a1, w1, s1, p1, e1, a2, w2, s2, p2, e2;

    always #5 sys_clk = ~sys_clk;

    sdram_write #(.TRCD_CLK(2), .TWR_CLK(2), .TRP_CLK(2), .COL_W(8)) u_dut_a (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .init_end(init_end), .wr_en(wr_en_a),
        .wr_addr_in(wr_addr_in), .wr_burst_len(wr_burst_len), .wr_data(wr_data),
        .wr_ack(ack_a), .wr_end(end_a), .wr_cmd(cmd_a), .wr_ba(ba_a), .wr_addr(addr_a),
        .wr_sdram_en(en_a), .wr_sdram_data(data_a)
    );

    sdram_write #(.TRCD_CLK(3), .TWR_CLK(1), .TRP_CLK(3), .COL_W(8)) u_dut_b (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .init_end(init_end), .wr_en(wr_en_b),
        .wr_addr_in(wr_addr_in), .wr_burst_len(wr_burst_len), .wr_data(wr_data),
        .wr_ack(ack_b), .wr_end(end_b), .wr_cmd(cmd_b), .wr_ba(ba_b), .wr_addr(addr_b),
        .wr_sdram_en(en_b), .wr_sdram_data(data_b)
    );

    // Observe whichever instance is under test
    always_comb begin
        m_ack  = sel ? ack_b  : ack_a;
        m_end  = sel ? end_b  : end_a;
        m_en   = sel ? en_b   : en_a;
        m_cmd  = sel ? cmd_b  : cmd_a;
        m_ba   = sel ? ba_b   : ba_a;
        m_addr = sel ? addr_b : addr_a;
        m_data = sel ? data_b : data_a;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] word(input int i);
        return {burst_tag, 24'(i)};
    endfunction

    // One clock: pop the show-ahead FIFO if last cycle acked, then sample at the falling edge
    task automatic tick();
        @(posedge sys_clk);
        if (last_ack) begin
            idx++;
            wr_data = word(idx);
        end
        @(negedge sys_clk);
        last_ack = m_ack;
        cyc++;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " cmd"},  32'(cmd_a),  32'(CMD_NOP));
        chk({tag, " ba"},   32'(ba_a),   32'h3);
        chk({tag, " addr"}, 32'(addr_a), 32'h7ff);
        chk({tag, " ack"},  32'(ack_a),  32'h0);
        chk({tag, " end"},  32'(end_a),  32'h0);
        chk({tag, " en"},   32'(en_a),   32'h0);
        chk({tag, " data"}, data_a,      32'h0);
    endtask

    // Run one burst and compare every cycle against the expected command timeline
    task automatic run_burst(input logic s, input logic [20:0] addr, input logic [9:0] len,
                             input int lead, input logic keep,
                             output int t_act, output int t_wr, output int t_stop,
                             output int t_pre, output int t_end);
        int T, W, P, L, a, wc, sc, pc, ec;
        logic [3:0]  e_cmd;
        logic [1:0]  e_ba;
        logic [10:0] e_addr;
        logic        e_ack, e_end;
        logic [31:0] e_data;
        T = s ? 3 : 2;
        W = s ? 1 : 2;
        P = s ? 3 : 2;
        L = (len == 10'd0) ? 1 : int'(len);
        sel          = s;
        wr_addr_in   = addr;
        wr_burst_len = len;
        init_end     = 1'b1;
        if (s) wr_en_b = 1'b1; else wr_en_a = 1'b1;
        burst_tag++;
        idx      = 0;
        wr_data  = word(0);
        last_ack = 1'b0;
        a  = lead;
        wc = a + T;
        sc = wc + L;
        pc = sc + W;
        ec = pc + P;
        t_act = -1; t_wr = -1; t_stop = -1; t_pre = -1; t_end = -1;
        for (int c = 1; c <= ec; c++) begin
            tick();
            e_cmd  = CMD_NOP;
            e_ba   = 2'b11;
            e_addr = 11'h7ff;
            if (c == a) begin
                e_cmd = CMD_ACTIVE; e_ba = addr[20:19]; e_addr = addr[18:8];
            end else if (c == wc) begin
                e_cmd = CMD_WRITE; e_ba = addr[20:19]; e_addr = {3'b000, addr[7:0]};
            end else if (c == sc) begin
                e_cmd = CMD_BURST_STOP;
            end else if (c == pc) begin
                e_cmd = CMD_PRECHARGE; e_addr = 11'h400;
            end
            e_ack  = (c >= wc) && (c < wc + L);
            e_data = e_ack ? word(c - wc) : 32'h0;
            e_end  = (c == ec);
            chk($sformatf("b%0h cmd c%0d", burst_tag, c),  32'(m_cmd),  32'(e_cmd));
            chk($sformatf("b%0h ba c%0d", burst_tag, c),   32'(m_ba),   32'(e_ba));
            chk($sformatf("b%0h addr c%0d", burst_tag, c), 32'(m_addr), 32'(e_addr));
            chk($sformatf("b%0h ack c%0d", burst_tag, c),  32'(m_ack),  32'(e_ack));
            chk($sformatf("b%0h en c%0d", burst_tag, c),   32'(m_en),   32'(e_ack));
            chk($sformatf("b%0h data c%0d", burst_tag, c), m_data,      e_data);
            chk($sformatf("b%0h end c%0d", burst_tag, c),  32'(m_end),  32'(e_end));
            if (m_cmd == CMD_ACTIVE && t_act < 0)     t_act  = cyc;
            if (m_cmd == CMD_WRITE && t_wr < 0)       t_wr   = cyc;
            if (m_cmd == CMD_BURST_STOP && t_stop < 0) t_stop = cyc;
            if (m_cmd == CMD_PRECHARGE && t_pre < 0)  t_pre  = cyc;
            if (m_end && t_end < 0)                   t_end  = cyc;
        end
        if (!keep) begin
            tick();
            chk($sformatf("b%0h idle cmd", burst_tag), 32'(m_cmd), 32'(CMD_NOP));
            chk($sformatf("b%0h idle end", burst_tag), 32'(m_end), 32'h0);
            if (s) wr_en_b = 1'b0; else wr_en_a = 1'b0;
            tick();
            chk($sformatf("b%0h idle2 cmd", burst_tag), 32'(m_cmd), 32'(CMD_NOP));
        end
    endtask

    initial begin
        n_checks = 0; n_bad = 0; cyc = 0; idx = 0; last_ack = 1'b0;
        burst_tag = 8'hD0; sel = 1'b0;
        sys_rst_n = 1'b0; init_end = 1'b0; wr_en_a = 1'b0; wr_en_b = 1'b0;
        wr_addr_in = '0; wr_burst_len = '0; wr_data = 32'hDEADBEEF;

        // Reset values
        #3;
        chk_reset_outputs("rst");
        chk("rst cmd_b", 32'(cmd_b), 32'(CMD_NOP));
        @(negedge sys_clk);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        tick();
        chk("post-rst idle cmd", 32'(m_cmd), 32'(CMD_NOP));

        // Basic burst, len=4
        run_burst(1'b0, {2'b01, 11'h123, 8'h10}, 10'd4, 1, 1'b0, a1, w1, s1, p1, e1);
        chk("basic act->end", 32'(e1 - a1), 32'd10);

        // len=1 and len=0 both behave as a single word
        run_burst(1'b0, {2'b10, 11'h3c5, 8'h80}, 10'd1, 1, 1'b0, a1, w1, s1, p1, e1);
        chk("len1 wr->stop", 32'(s1 - w1), 32'd1);
        run_burst(1'b0, {2'b11, 11'h00f, 8'hff}, 10'd0, 1, 1'b0, a1, w1, s1, p1, e1);
        chk("len0 wr->stop", 32'(s1 - w1), 32'd1);

        // Full page from col F0 (wraps inside the row)
        run_burst(1'b0, {2'b00, 11'h055, 8'hF0}, 10'd256, 1, 1'b0, a1, w1, s1, p1, e1);
        chk("len256 wr->stop", 32'(s1 - w1), 32'd256);

        // wr_en ignored until init_end
        sel = 1'b0; init_end = 1'b0; wr_en_a = 1'b1;
        wr_addr_in = {2'b01, 11'h001, 8'h02}; wr_burst_len = 10'd2;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk($sformatf("noinit cmd c%0d", i), 32'(m_cmd), 32'(CMD_NOP));
            chk($sformatf("noinit ack c%0d", i), 32'(m_ack), 32'h0);
        end
        run_burst(1'b0, {2'b01, 11'h001, 8'h02}, 10'd2, 1, 1'b0, a1, w1, s1, p1, e1);

        // Reset asserted during word 2 of an 8-word burst
        sel = 1'b0; init_end = 1'b1; wr_en_a = 1'b1;
        wr_addr_in = {2'b01, 11'h2aa, 8'h04}; wr_burst_len = 10'd8;
        burst_tag++; idx = 0; wr_data = word(0); last_ack = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("midrst pre ack", 32'(m_ack), 32'h1);
        chk("midrst pre data", m_data, word(2));
        #2;
        sys_rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        wr_en_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("midrst hold end c%0d", i), 32'(m_end), 32'h0);
        end
        last_ack = 1'b0;
        sys_rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("midrst idle cmd c%0d", i), 32'(m_cmd), 32'(CMD_NOP));
            chk($sformatf("midrst idle end c%0d", i), 32'(m_end), 32'h0);
        end
        run_burst(1'b0, {2'b10, 11'h444, 8'h20}, 10'd3, 1, 1'b0, a1, w1, s1, p1, e1);

        // Back-to-back on the (3,1,3) instance with grant held across wr_end
        run_burst(1'b1, {2'b01, 11'h10a, 8'h33}, 10'd3, 1, 1'b1, a1, w1, s1, p1, e1);
        run_burst(1'b1, {2'b10, 11'h20b, 8'h44}, 10'd5, 2, 1'b0, a2, w2, s2, p2, e2);
        chk("b2b act->wr 1",  32'(w1 - a1), 32'd3);
        chk("b2b stop->pre 1", 32'(p1 - s1), 32'd1);
        chk("b2b pre->end 1", 32'(e1 - p1), 32'd3);
        chk("b2b end->act2",  32'(a2 - e1), 32'd2);
        chk("b2b act->wr 2",  32'(w2 - a2), 32'd3);
        chk("b2b pre->end 2", 32'(e2 - p2), 32'd3);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
